// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor (FIPS-197 InvCipher), one round per clock.
// The decryption key schedule is regenerated on the fly. The key is first
// expanded forward to rk10, then stepped backward by one round key per round.
// Bit 0 of every 128-bit port is the MSB of byte 0. Internally the vectors are
// held as [127:0], so byte i sits at [127-8*i -: 8].

// Inverse S-box ROM: purely combinational, one byte in and one byte out.
module aes_inv_sbox (
  input  logic [7:0] a_in,
  output logic [7:0] y_out
);

  // Entry for byte value b is found at bit offset (255-b)*8, counted from the LSB.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y_out = INV_SBOX_TBL[{~a_in, 3'b000} +: 8];

endmodule

module aes_inv_cipher_iter #(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic [0:127] ct_in,
  input  logic [0:127] key_in,
  output logic [0:127] pt_out,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, KEXP, ADDK, ROUND} state_e;

  // Forward S-box table. The key schedule needs it in both directions.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant. The bits of k select a, 2a, 4a and 8a.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] pt_q, pt_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, sw_in, g_word;
  logic [127:0] key_fwd, key_bwd, round_out;
  logic [7:0]   isr [16];
  logic [7:0]   isb [16];
  logic [7:0]   ark [16];

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Both key directions share one SubWord(RotWord()). Backward steps feed it the regenerated w3.
  always_comb begin
    logic [31:0] rot;
    sw_in  = (state_q == ROUND) ? (w3 ^ w2) : w3;
    rot    = {sw_in[23:0], sw_in[31:24]};
    g_word = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
             ^ {rcon(rc_q), 24'h000000};
  end

  // Forward rk(rc-1)->rk(rc) and backward rk(rc)->rk(rc-1) key steps.
  always_comb begin
    logic [31:0] f0, f1, f2;
    f0      = w0 ^ g_word;
    f1      = w1 ^ f0;
    f2      = w2 ^ f1;
    key_fwd = {f0, f1, f2, w3 ^ f2};
    key_bwd = {w0 ^ g_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  // InvShiftRows: row r rotates right by r, so out[r][c] = in[r][(c-r) mod 4].
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[r + 4*c] = st_q[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_isb
    aes_inv_sbox u_isb (.a_in(isr[gi]), .y_out(isb[gi]));
  end

  // AddRoundKey with rk(rc-1), followed by InvMixColumns except in the final round.
  always_comb begin
    round_out = '0;
    for (int i = 0; i < 16; i++) begin
      ark[i] = isb[i] ^ key_bwd[127 - 8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      if (rc_q == 4'd1) begin
        for (int r = 0; r < 4; r++) begin
          round_out[127 - 8*(4*c + r) -: 8] = ark[4*c + r];
        end
      end else begin
        round_out[127 - 8*(4*c + 0) -: 8] = gmul(ark[4*c], 4'he) ^ gmul(ark[4*c+1], 4'hb) ^
                                            gmul(ark[4*c+2], 4'hd) ^ gmul(ark[4*c+3], 4'h9);
        round_out[127 - 8*(4*c + 1) -: 8] = gmul(ark[4*c], 4'h9) ^ gmul(ark[4*c+1], 4'he) ^
                                            gmul(ark[4*c+2], 4'hb) ^ gmul(ark[4*c+3], 4'hd);
        round_out[127 - 8*(4*c + 2) -: 8] = gmul(ark[4*c], 4'hd) ^ gmul(ark[4*c+1], 4'h9) ^
                                            gmul(ark[4*c+2], 4'he) ^ gmul(ark[4*c+3], 4'hb);
        round_out[127 - 8*(4*c + 3) -: 8] = gmul(ark[4*c], 4'hb) ^ gmul(ark[4*c+1], 4'hd) ^
                                            gmul(ark[4*c+2], 4'h9) ^ gmul(ark[4*c+3], 4'he);
      end
    end
  end

  // Sequencer next state: IDLE -> KEXP(10) -> ADDK(1) -> ROUND(10) -> IDLE.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    rc_d    = rc_q;
    pt_d    = pt_q;
    ready_d = ready_q;
    done_d  = DONE_PULSE ? 1'b0 : done_q;
    case (state_q)
      IDLE: begin
        if (start && ready_q) begin
          state_d = KEXP;
          st_d    = ct_in;
          key_d   = key_in;
          rc_d    = 4'd1;
          ready_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      KEXP: begin
        key_d = key_fwd;
        if (rc_q == 4'd10) begin
          state_d = ADDK;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      ADDK: begin
        st_d    = st_q ^ key_q;
        state_d = ROUND;
      end
      ROUND: begin
        key_d = key_bwd;
        st_d  = round_out;
        rc_d  = rc_q - 4'd1;
        if (rc_q == 4'd1) begin
          pt_d    = round_out;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      pt_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      pt_q    <= pt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign pt_out = pt_q;

endmodule
